// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: takes one vector or scalar memory request and issues
// its active lanes one at a time, lowest lane first, on a single dcache port.
// All load data comes back together in one response beat.
// Optional feature macro: VMS_LOAD_COALESCE_EN. When it is defined, load lanes
// that share an address are all satisfied by the same dcache access.
module vector_mem_sequencer #(
    parameter int LANES = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_vector,
    input  logic [LANES-1:0]      lane_mask,
    input  logic [LANES*AW-1:0]   req_addr,
    input  logic [LANES*DW-1:0]   req_wdata,
    output logic                  resp_valid,
    output logic [LANES*DW-1:0]   resp_rdata,
    output logic                  dmemREN,
    output logic                  dmemWEN,
    output logic [AW-1:0]         dmemaddr,
    output logic [DW-1:0]         dmemstore,
    input  logic                  dcacheHit,
    input  logic [DW-1:0]         dmemload
);

    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  write_r;
    logic [LANES*AW-1:0]   addr_r;
    logic [LANES*DW-1:0]   wdata_r;
    logic [LANES-1:0]      pending_r;
    logic [LANES-1:0]      pending_nxt_s;
    logic [LANES*DW-1:0]   rdata_r;
    logic [LANES*DW-1:0]   rdata_nxt_s;
    logic [LANES-1:0]      served_s;
    logic                  capture_s;
    logic                  in_issue_s;
    logic [LW-1:0]         cur_s;
    logic [AW-1:0]         cur_addr_s;

    // Pick the lowest pending lane; scanning downwards leaves the smallest index.
    always_comb begin
        cur_s = {LW{1'b0}};
        for (int i = LANES - 1; i >= 0; i--) begin
            cur_s = pending_r[i] ? LW'(i) : cur_s;
        end
    end

    assign cur_addr_s = addr_r[int'(cur_s)*AW +: AW];
    assign in_issue_s = (state_r == ISSUE);

    // Lanes retired by a hit on the current access (only the current one unless loads coalesce).
    always_comb begin
        served_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
`ifdef VMS_LOAD_COALESCE_EN
            served_s[i] = (cur_s == LW'(i)) ||
                          (!write_r && pending_r[i] && (addr_r[i*AW +: AW] == cur_addr_s));
`else
            served_s[i] = (cur_s == LW'(i));
`endif
        end
    end

    // Next-state, pending-lane and response-data update logic.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        rdata_nxt_s   = rdata_r;
        capture_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    capture_s     = 1'b1;
                    pending_nxt_s = req_vector ? lane_mask : {{(LANES-1){1'b0}}, 1'b1};
                    rdata_nxt_s   = {(LANES*DW){1'b0}};
                    state_nxt_s   = (pending_nxt_s != {LANES{1'b0}}) ? ISSUE : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (dcacheHit) begin
                    pending_nxt_s = pending_r & ~served_s;
                    for (int i = 0; i < LANES; i++) begin
                        if (!write_r && served_s[i]) begin
                            rdata_nxt_s[i*DW +: DW] = dmemload;
                        end else begin
                            rdata_nxt_s[i*DW +: DW] = rdata_r[i*DW +: DW];
                        end
                    end
                    state_nxt_s = (pending_nxt_s == {LANES{1'b0}}) ? DONE : ISSUE;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s   = IDLE;
                pending_nxt_s = {LANES{1'b0}};
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture, pending mask and gathered load data.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            write_r   <= 1'b0;
            addr_r    <= {(LANES*AW){1'b0}};
            wdata_r   <= {(LANES*DW){1'b0}};
            pending_r <= {LANES{1'b0}};
            rdata_r   <= {(LANES*DW){1'b0}};
        end else begin
            if (capture_s) begin
                write_r <= req_write;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            pending_r <= pending_nxt_s;
            rdata_r   <= rdata_nxt_s;
        end
    end

    // Port outputs decode from registered state only; the dcache side is quiet outside ISSUE.
    assign req_ready  = (state_r == IDLE);
    assign resp_valid = (state_r == DONE);
    assign resp_rdata = rdata_r;
    assign dmemREN    = in_issue_s && !write_r;
    assign dmemWEN    = in_issue_s && write_r;
    assign dmemaddr   = in_issue_s ? cur_addr_s : {AW{1'b0}};
    assign dmemstore  = in_issue_s ? wdata_r[int'(cur_s)*DW +: DW] : {DW{1'b0}};

endmodule
